// File: rtl/vscale_dmem_responder_pkg.sv
// Shared constants for the dmem responder: word width, size codes, FSM states.
// Pure declarations, no timing.
// No flow control of its own.
package vscale_dmem_responder_pkg;

  localparam int XPR_LEN        = 32;
  localparam int MEM_TYPE_WIDTH = 3;

  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_SB = 3'd0;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_SH = 3'd1;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_SW = 3'd2;

  typedef enum logic [1:0] {
    DMEM_RESP_IDLE = 2'd0,
    DMEM_RESP_WAIT = 2'd1,
    DMEM_RESP_DATA = 2'd2
  } dmem_resp_state_t;

  // Replace the byte lanes selected by mask with the lanes of new_word.
  function automatic logic [XPR_LEN-1:0] merge_lanes(input logic [XPR_LEN-1:0] old_word,
                                                     input logic [XPR_LEN-1:0] new_word,
                                                     input logic [3:0]         mask);
    logic [XPR_LEN-1:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/vscale_dmem_responder_if.sv
// Two-phase pipelined dmem port between the core (master) and the memory (slave).
// Address phase in cycle N, data phase from cycle N+1.
// dmem_wait from the slave freezes every master-driven signal.
interface vscale_dmem_responder_if;
  import vscale_dmem_responder_pkg::*;

  logic                      dmem_en;
  logic                      dmem_wen;
  logic [MEM_TYPE_WIDTH-1:0] dmem_size;
  logic [XPR_LEN-1:0]        dmem_addr;
  logic [XPR_LEN-1:0]        dmem_wdata_delayed;
  logic [XPR_LEN-1:0]        dmem_rdata;
  logic                      dmem_wait;
  logic                      dmem_badmem_e;

  modport master (
    output dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
    input  dmem_rdata, dmem_wait, dmem_badmem_e
  );

  modport slave (
    input  dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
    output dmem_rdata, dmem_wait, dmem_badmem_e
  );

endinterface

// File: rtl/vscale_mem_wmask.sv
// Byte-lane mask and alignment/size legality for a dmem access.
// Purely combinational.
// No flow control.
module vscale_mem_wmask
  import vscale_dmem_responder_pkg::*;
(
  input  logic [MEM_TYPE_WIDTH-1:0] size,
  input  logic [1:0]                offset,
  output logic [3:0]                mask,
  output logic                      misalign,
  output logic                      bad_size
);

  // Lane select per access size; halfwords must be even, words 4-aligned.
  always_comb begin
    mask     = 4'b0000;
    misalign = 1'b0;
    bad_size = 1'b0;
    case (size)
      MEM_TYPE_SB: mask = 4'b0001 << offset;
      MEM_TYPE_SH: begin
        mask     = 4'b0011 << offset;
        misalign = offset[0];
      end
      MEM_TYPE_SW: begin
        mask     = 4'b1111;
        misalign = |offset;
      end
      default: bad_size = 1'b1;
    endcase
  end

endmodule

// File: rtl/vscale_dmem_responder.sv
// Word-organised data memory behind the pipelined dmem port, with fault reporting.
// Result in the final data-phase cycle, WAIT_CYCLES cycles after the first data cycle.
// Holds dmem_wait high for WAIT_CYCLES cycles per access; no capture while waiting.
module vscale_dmem_responder
  import vscale_dmem_responder_pkg::*;
#(
  parameter int                 WORDS       = 1024,
  parameter logic [XPR_LEN-1:0] BASE_ADDR   = 32'h0,
  parameter int                 WAIT_CYCLES = 0
) (
  input logic                     clk,
  input logic                     reset,
  vscale_dmem_responder_if.slave  dmem
);

  localparam int           IDX_W    = $clog2(WORDS);
  localparam logic [32:0]  SPAN     = 33'(longint'(WORDS) * 4);
  localparam logic [3:0]   CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  dmem_resp_state_t   state;
  logic [3:0]         cnt;
  logic               req_wen;
  logic               req_bad;
  logic [IDX_W-1:0]   req_idx;
  logic [3:0]         req_mask;

  logic [XPR_LEN-1:0] mem [WORDS];

  logic [3:0]         in_mask;
  logic               in_misalign;
  logic               in_bad_size;
  logic [XPR_LEN-1:0] in_off;
  logic               in_range;
  logic               in_bad;
  logic [IDX_W-1:0]   in_idx;
  logic               take;
  logic               commit;
  logic [XPR_LEN-1:0] in_word;
  logic [XPR_LEN-1:0] req_word;

  vscale_mem_wmask u_wmask (
    .size     (dmem.dmem_size),
    .offset   (dmem.dmem_addr[1:0]),
    .mask     (in_mask),
    .misalign (in_misalign),
    .bad_size (in_bad_size)
  );

  // Decode the address phase and the store committing at the coming edge; a load
  // captured on that edge gets the store's lanes forwarded so it never sees stale data.
  always_comb begin
    in_off   = dmem.dmem_addr - BASE_ADDR;
    in_range = (dmem.dmem_addr >= BASE_ADDR) && ({1'b0, in_off} < SPAN);
    in_bad   = in_bad_size || in_misalign || !in_range;
    in_idx   = in_off[IDX_W+1:2];
    take     = dmem.dmem_en && (state != DMEM_RESP_WAIT);
    commit   = (state == DMEM_RESP_DATA) && req_wen && !req_bad;
    in_word  = mem[in_idx];
    if (commit && (in_idx == req_idx))
      in_word = merge_lanes(mem[req_idx], dmem.dmem_wdata_delayed, req_mask);
    req_word = mem[req_idx];
  end

  // Access FSM; outputs are registered for the cycle the FSM moves into.
  // Stores return rdata 0: only loads carry data back to the core.
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= DMEM_RESP_IDLE;
      cnt                <= 4'd0;
      req_wen            <= 1'b0;
      req_bad            <= 1'b0;
      req_idx            <= '0;
      req_mask           <= 4'b0000;
      dmem.dmem_wait     <= 1'b0;
      dmem.dmem_badmem_e <= 1'b0;
      dmem.dmem_rdata    <= '0;
    end else begin
      dmem.dmem_wait     <= 1'b0;
      dmem.dmem_badmem_e <= 1'b0;
      dmem.dmem_rdata    <= '0;
      case (state)
        DMEM_RESP_WAIT: begin
          if (cnt == 4'd0) begin
            state              <= DMEM_RESP_DATA;
            dmem.dmem_badmem_e <= req_bad;
            dmem.dmem_rdata    <= (req_bad || req_wen) ? '0 : req_word;
          end else begin
            cnt            <= cnt - 4'd1;
            dmem.dmem_wait <= 1'b1;
          end
        end
        default: begin
          if (take) begin
            req_wen  <= dmem.dmem_wen;
            req_bad  <= in_bad;
            req_idx  <= in_idx;
            req_mask <= in_mask;
            if (WAIT_CYCLES > 0) begin
              state          <= DMEM_RESP_WAIT;
              cnt            <= CNT_INIT;
              dmem.dmem_wait <= 1'b1;
            end else begin
              state              <= DMEM_RESP_DATA;
              dmem.dmem_badmem_e <= in_bad;
              dmem.dmem_rdata    <= (in_bad || dmem.dmem_wen) ? '0 : in_word;
            end
          end else begin
            state <= DMEM_RESP_IDLE;
          end
        end
      endcase
    end
  end

  // Store commit at the edge that ends the data phase; reset aborts it.
  always_ff @(posedge clk) begin
    if (!reset && commit) begin
      for (int b = 0; b < 4; b++) begin
        if (req_mask[b]) mem[req_idx][8*b +: 8] <= dmem.dmem_wdata_delayed[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_vscale_dmem_responder.sv
// Bench for vscale_dmem_responder: three instances (0, 3 and 2 wait states),
// a pipelined core-like driver and a byte-addressed reference memory.
module tb_vscale_dmem_responder;
  import vscale_dmem_responder_pkg::*;

  typedef struct {
    bit          bub;
    bit          wen;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } op_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        en, wen;
  logic [2:0]  size;
  logic [31:0] addr, wdata;
  logic [1:0]  sel;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  int     wc    [3] = '{0, 3, 2};
  longint base  [3] = '{64'h0, 64'h0, 64'h100};
  longint words [3] = '{1024, 1024, 64};

  logic [7:0]  ref_mem [longint];
  op_t         q [$];
  logic [31:0] last_rd;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vscale_dmem_responder_if bus [3] ();

  logic [2:0]  w_v, bm_v;
  logic [31:0] rd_v [3];
  logic        w_o, bm_o;
  logic [31:0] rd_o;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign bus[g].dmem_en            = en && (sel == 2'(g));
    assign bus[g].dmem_wen           = wen;
    assign bus[g].dmem_size          = size;
    assign bus[g].dmem_addr          = addr;
    assign bus[g].dmem_wdata_delayed = wdata;
    assign w_v[g]  = bus[g].dmem_wait;
    assign bm_v[g] = bus[g].dmem_badmem_e;
    assign rd_v[g] = bus[g].dmem_rdata;
    vscale_dmem_responder #(
      .WORDS       ((g == 2) ? 64 : 1024),
      .BASE_ADDR   ((g == 2) ? 32'h100 : 32'h0),
      .WAIT_CYCLES ((g == 0) ? 0 : ((g == 1) ? 3 : 2))
    ) dut (
      .clk   (clk),
      .reset (reset),
      .dmem  (bus[g])
    );
  end

  assign w_o  = w_v[sel];
  assign bm_o = bm_v[sel];
  assign rd_o = rd_v[sel];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (dut %0d, cycle %0d)", tag, got, exp, sel, cyc);
  endtask

  function automatic op_t mk(input bit w, input logic [2:0] sz, input logic [31:0] a,
                             input logic [31:0] d);
    op_t o;
    o.bub = 1'b0; o.wen = w; o.size = sz; o.addr = a; o.wdata = d;
    return o;
  endfunction

  function automatic bit is_bad(input int s, input logic [2:0] sz, input logic [31:0] a);
    longint la = longint'(a);
    if (sz > 3'd2) return 1'b1;
    if (sz == 3'd1 && a[0]) return 1'b1;
    if (sz == 3'd2 && a[1:0] != 2'b00) return 1'b1;
    if (la < base[s] || la >= base[s] + 4 * words[s]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic longint key(input int s, input logic [31:0] a);
    return (longint'(s) << 32) | longint'(a);
  endfunction

  function automatic logic [31:0] ref_word(input int s, input logic [31:0] a);
    logic [31:0] w;
    longint k = key(s, {a[31:2], 2'b00});
    for (int b = 0; b < 4; b++) w[8*b +: 8] = ref_mem.exists(k + b) ? ref_mem[k + b] : 8'h00;
    return w;
  endfunction

  // Byte-granular store: SB one byte, SH two bytes, SW the whole word, at the lanes
  // matching the byte address.
  task automatic ref_store(input int s, input op_t o);
    int n, lo;
    longint k = key(s, {o.addr[31:2], 2'b00});
    n  = (o.size == 3'd0) ? 1 : (o.size == 3'd1) ? 2 : 4;
    lo = (o.size == 3'd2) ? 0 : int'(o.addr[1:0]);
    for (int b = lo; b < lo + n; b++) ref_mem[k + b] = o.wdata[8*b +: 8];
  endtask

  // Core-like pipelined driver for the ops in q. Entered and left #1 after a posedge.
  task automatic run_ops();
    op_t off, pend;
    bit  have_off, have_pend, cap, w_prev, off_tight, bad;
    int  cap_cyc, prev_cap, wcnt, budget;
    have_off = 0; have_pend = 0; cap = 0; off_tight = 0;
    prev_cap = -1; cap_cyc = 0; wcnt = 0; budget = 0;
    w_prev = w_o;
    while ((q.size() > 0 || have_off || have_pend) && budget < 4000) begin
      if (cap) begin
        pend = off; have_pend = 1; wcnt = 0; cap_cyc = cyc;
        if (off_tight && prev_cap >= 0) check("gap", 64'(cyc - prev_cap), 64'(wc[sel] + 1));
        prev_cap = cyc;
      end
      if (!have_off || cap || (off.bub && !w_prev)) begin
        have_off = 0; off_tight = 0;
        if (q.size() > 0) begin
          off = q.pop_front(); have_off = 1; off_tight = cap;
        end
      end
      en    = have_off && !off.bub;
      wen   = have_off ? off.wen : 1'b0;
      size  = have_off ? off.size : 3'd0;
      addr  = have_off ? off.addr : 32'h0;
      wdata = have_pend ? pend.wdata : 32'h0;
      @(negedge clk);
      w_prev = w_o;
      if (have_pend && !w_o) begin
        bad = is_bad(sel, pend.size, pend.addr);
        check("badmem", 64'(bm_o), 64'(bad));
        check("wait_cnt", 64'(wcnt), 64'(wc[sel]));
        check("latency", 64'(cyc - cap_cyc), 64'(wc[sel]));
        if (!pend.wen) begin
          check("rdata", 64'(rd_o), bad ? 64'h0 : 64'(ref_word(sel, pend.addr)));
          last_rd = rd_o;
        end else if (!bad) begin
          ref_store(sel, pend);
        end
        have_pend = 0;
      end else if (have_pend) begin
        wcnt++;
        check("stall_out", {bm_o, rd_o}, 64'h0);
      end else begin
        check("idle_out", {w_o, bm_o, rd_o}, 64'h0);
      end
      cap = have_off && !off.bub && !w_o;
      @(posedge clk);
      #1;
      budget++;
    end
    if (budget >= 4000) check("run_budget", 64'd1, 64'd0);
    en = 1'b0; wen = 1'b0; size = 3'd0; addr = 32'h0; wdata = 32'h0;
  endtask

  function automatic op_t rand_op(input int s);
    op_t o;
    o.bub   = ($urandom_range(0, 9) == 0);
    o.wen   = 1'($urandom_range(0, 1));
    o.size  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
    o.wdata = $urandom;
    if ($urandom_range(0, 9) == 0) begin
      case ($urandom_range(0, 3))
        0:       o.addr = 32'(base[s] - 4);
        1:       o.addr = 32'(base[s] + 4 * words[s]);
        2:       o.addr = 32'(base[s] + 4 * words[s] + 2);
        default: o.addr = 32'hFFFF_FFFC;
      endcase
    end else begin
      o.addr = 32'(base[s] + longint'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) != 0) begin
        if (o.size == 3'd1) o.addr[0] = 1'b0;
        if (o.size == 3'd2) o.addr[1:0] = 2'b00;
      end
    end
    return o;
  endfunction

  initial begin
    logic [31:0] exp;
    reset = 1'b1; en = 1'b0; wen = 1'b0; size = 3'd0; addr = 32'h0; wdata = 32'h0; sel = 2'd0;
    last_rd = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      check("reset_out", {w_o, bm_o, rd_o}, 64'h0);
    end
    sel = 2'd0;
    reset = 1'b0;
    @(posedge clk); #1;

    // Store then load on the very next cycle, no wait states.
    q.push_back(mk(1, MEM_TYPE_SW, 32'h10, 32'hDEAD_BEEF));
    q.push_back(mk(0, MEM_TYPE_SW, 32'h10, 32'h0));
    run_ops();
    check("sw_lw", 64'(last_rd), 64'hDEAD_BEEF);

    // Byte lanes at every offset, halfword lanes at both even offsets.
    for (int k = 0; k < 4; k++) begin
      q.push_back(mk(1, MEM_TYPE_SW, 32'h10, 32'h1122_3344));
      q.push_back(mk(1, MEM_TYPE_SB, 32'(32'h10 + k), 32'h5A5A_5A5A));
      q.push_back(mk(0, MEM_TYPE_SW, 32'h10, 32'h0));
      run_ops();
      exp = 32'h1122_3344;
      exp[8*k +: 8] = 8'h5A;
      check("sb_lane", 64'(last_rd), 64'(exp));
    end
    for (int k = 0; k < 4; k += 2) begin
      q.push_back(mk(1, MEM_TYPE_SW, 32'h10, 32'h1122_3344));
      q.push_back(mk(1, MEM_TYPE_SH, 32'(32'h10 + k), 32'hBEEF_BEEF));
      q.push_back(mk(0, MEM_TYPE_SW, 32'h10, 32'h0));
      run_ops();
      check("sh_lane", 64'(last_rd), (k == 0) ? 64'h1122_BEEF : 64'hBEEF_3344);
    end

    // Faulting accesses; faulted stores must leave memory alone.
    q.push_back(mk(1, MEM_TYPE_SW, 32'h10, 32'h1122_3344));
    q.push_back(mk(0, MEM_TYPE_SH, 32'h11, 32'h0));
    q.push_back(mk(0, MEM_TYPE_SW, 32'h12, 32'h0));
    q.push_back(mk(0, 3'd3, 32'h10, 32'h0));
    q.push_back(mk(0, MEM_TYPE_SW, 32'h1000, 32'h0));
    q.push_back(mk(1, MEM_TYPE_SW, 32'h12, 32'hFFFF_FFFF));
    q.push_back(mk(1, 3'd3, 32'h10, 32'hFFFF_FFFF));
    q.push_back(mk(0, MEM_TYPE_SW, 32'h10, 32'h0));
    run_ops();
    check("fault_keep", 64'(last_rd), 64'h1122_3344);

    // Three wait states, back-to-back accesses held through the stall.
    sel = 2'd1;
    q.push_back(mk(1, MEM_TYPE_SW, 32'h40, 32'hCAFE_F00D));
    q.push_back(mk(0, MEM_TYPE_SW, 32'h40, 32'h0));
    q.push_back(mk(0, MEM_TYPE_SW, 32'h40, 32'h0));
    q.push_back(mk(1, MEM_TYPE_SW, 32'h20, 32'h0000_0077));
    run_ops();
    check("wait3_lw", 64'(last_rd), 64'hCAFE_F00D);

    // Reset during the wait of a store aborts it.
    en = 1'b1; wen = 1'b1; size = MEM_TYPE_SW; addr = 32'h20; wdata = 32'h0;
    @(negedge clk); @(posedge clk); #1;
    en = 1'b0; wen = 1'b0; wdata = 32'h1;
    @(negedge clk);
    check("rst_in_wait", 64'(w_o), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; wdata = 32'h0;
    @(negedge clk);
    check("rst_abort", {w_o, bm_o, rd_o}, 64'h0);
    @(posedge clk); #1;
    q.push_back(mk(0, MEM_TYPE_SW, 32'h20, 32'h0));
    run_ops();
    check("rst_keep", 64'(last_rd), 64'h0000_0077);

    // Random mixed traffic against the reference memory, 0 and 2 wait states.
    for (int s = 0; s < 3; s += 2) begin
      sel = 2'(s);
      for (int i = 0; i < 64; i++)
        q.push_back(mk(1, MEM_TYPE_SW, 32'(base[s] + 4 * i), $urandom));
      run_ops();
      for (int i = 0; i < 300; i++) q.push_back(rand_op(s));
      run_ops();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
